// File: rtl/duty_clkdiv.sv
// Programmable duty-cycle clock divider with double-buffered high/low config.
// Optional DUTY_CLKDIV_PERIOD_COUNT_EN adds a 16-bit period_count output.
module duty_clkdiv #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] low_cnt,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             busy,
`ifdef DUTY_CLKDIV_PERIOD_COUNT_EN
  output logic [15:0]      period_count,
`endif
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_act_high, r_act_low;
  logic [CNT_W-1:0] r_pend_high, r_pend_low;
  logic             r_pend_valid;
  logic             r_clk_out, r_rise, r_fall, r_busy, r_cfg_err;

  logic w_load_ok, w_load_bad, w_start, w_apply;

  assign w_load_ok  = load && (high_cnt != '0) && (low_cnt != '0);
  assign w_load_bad = load && !w_load_ok;
  // A new period starts from IDLE or at the end of a LOW phase, only if enabled.
  assign w_start    = enable && ((r_state == IDLE) ||
                                 ((r_state == LOW) && (r_cnt == r_act_low)));
  assign w_apply    = w_start && r_pend_valid;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= ONE;
      r_act_high   <= ONE;
      r_act_low    <= ONE;
      r_pend_high  <= ONE;
      r_pend_low   <= ONE;
      r_pend_valid <= 1'b0;
      r_clk_out    <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_busy       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_cfg_err <= w_load_bad;
      if (w_apply) begin
        r_act_high   <= r_pend_high;
        r_act_low    <= r_pend_low;
        r_pend_valid <= 1'b0;
      end
      // A load on an apply cycle re-arms pending after the old values move over.
      if (w_load_ok) begin
        r_pend_high  <= high_cnt;
        r_pend_low   <= low_cnt;
        r_pend_valid <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_clk_out <= 1'b0;
          if (enable) begin
            r_state   <= HIGH;
            r_cnt     <= ONE;
            r_clk_out <= 1'b1;
            r_rise    <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        HIGH: begin
          if (r_cnt == r_act_high) begin
            r_state   <= LOW;
            r_cnt     <= ONE;
            r_clk_out <= 1'b0;
            r_fall    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        LOW: begin
          if (r_cnt == r_act_low) begin
            r_cnt <= ONE;
            if (enable) begin
              r_state   <= HIGH;
              r_clk_out <= 1'b1;
              r_rise    <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_clk_out <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DUTY_CLKDIV_PERIOD_COUNT_EN
  logic [15:0] r_period_count;
  logic        w_rise_next;

  assign w_rise_next = w_start;

  // Counts alongside rise_tick so the value changes in the same cycle as the tick.
  always_ff @(posedge clock) begin
    if (!reset_n) r_period_count <= 16'd0;
    else if (w_rise_next) r_period_count <= r_period_count + 16'd1;
  end

  assign period_count = r_period_count;
`endif

  assign clk_out   = r_clk_out;
  assign rise_tick = r_rise;
  assign fall_tick = r_fall;
  assign busy      = r_busy;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_duty_clkdiv.sv
module tb_duty_clkdiv;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset_n, enable, load;
  logic [CNT_W-1:0] high_cnt, low_cnt;
  logic             clk_out, rise_tick, fall_tick, busy, cfg_err;
  logic [15:0]      pc_act;

  always #5 clock = ~clock;

  duty_clkdiv #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(load),
    .high_cnt(high_cnt), .low_cnt(low_cnt),
    .clk_out(clk_out), .rise_tick(rise_tick), .fall_tick(fall_tick), .busy(busy),
`ifdef DUTY_CLKDIV_PERIOD_COUNT_EN
    .period_count(pc_act),
`endif
    .cfg_err(cfg_err)
  );
`ifndef DUTY_CLKDIV_PERIOD_COUNT_EN
  assign pc_act = 16'd0;
`endif

  typedef struct packed {logic clk, rise, fall, busy;} ph_t;
  typedef struct packed {logic clk, rise, fall, busy, err; logic [15:0] pc;} exp_t;

  ph_t  plan[$];
  exp_t sbq[$];
  int   m_ah = 1, m_al = 1, m_ph = 1, m_pl = 1;
  bit   m_pv = 0;
  logic [15:0] m_pc = 16'd0;
  int   n_tests = 0, n_fail = 0, n_cyc = 0;

  always @(posedge clock) begin
    ph_t  nx;
    exp_t e;
    bit   ok;
    ok = load && (high_cnt != 0) && (low_cnt != 0);
    if (!reset_n) begin
      plan.delete();
      m_ah = 1; m_al = 1; m_pv = 0; m_pc = 16'd0;
      e = '0;
    end else begin
      if (plan.size() == 0 && enable) begin
        if (m_pv) begin m_ah = m_ph; m_al = m_pl; m_pv = 0; end
        for (int i = 0; i < m_ah; i++) plan.push_back({1'b1, (i == 0), 1'b0, 1'b1});
        for (int i = 0; i < m_al; i++) plan.push_back({1'b0, 1'b0, (i == 0), 1'b1});
      end
      if (ok) begin m_ph = int'(high_cnt); m_pl = int'(low_cnt); m_pv = 1; end
      if (plan.size() != 0) nx = plan.pop_front();
      else nx = '0;
      if (nx.rise) m_pc = m_pc + 16'd1;
      e = {nx.clk, nx.rise, nx.fall, nx.busy, (load && !ok), m_pc};
    end
    sbq.push_back(e);
  end

  always @(negedge clock) begin
    exp_t e;
    bit   bad;
    n_cyc++;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      bad = {clk_out, rise_tick, fall_tick, busy, cfg_err} !=
            {e.clk, e.rise, e.fall, e.busy, e.err};
`ifdef DUTY_CLKDIV_PERIOD_COUNT_EN
      if (pc_act != e.pc) bad = 1;
`endif
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL cyc%0d outputs: got clk=%b rise=%b fall=%b busy=%b err=%b pc=%0d, expected clk=%b rise=%b fall=%b busy=%b err=%b pc=%0d",
                 n_cyc, clk_out, rise_tick, fall_tick, busy, cfg_err, pc_act,
                 e.clk, e.rise, e.fall, e.busy, e.err, e.pc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input bit cond, input string msg);
    n_tests++;
    if (!cond) begin
      n_fail++;
      $display("FAIL cyc%0d %s: clk=%b rise=%b fall=%b busy=%b err=%b",
               n_cyc, msg, clk_out, rise_tick, fall_tick, busy, cfg_err);
    end
  endtask

  task automatic chk_reset(input string msg);
    chk({clk_out, rise_tick, fall_tick, busy, cfg_err} == 5'b0, msg);
  endtask

  task automatic do_load(input int h, input int l);
    load = 1'b1; high_cnt = CNT_W'(h); low_cnt = CNT_W'(l);
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    int r, w;
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; high_cnt = '0; low_cnt = '0;
    cyc(3);
    chk_reset("reset state");
    reset_n = 1'b1; enable = 1'b1;
    w = 0;
    while (!rise_tick && w < 8) begin cyc(1); w++; end
    chk(rise_tick == 1'b1, "wait for first rise_tick expired");
    cyc(8 - w);
    enable = 1'b0; cyc(4);
    do_load(3, 7); cyc(2);
    enable = 1'b1; cyc(12);
    do_load(2, 2); cyc(14);
    do_load(5, 5); cyc(30);
    do_load(0, 4); cyc(6);
    do_load(4, 0); cyc(6);
    do_load(3, 7); cyc(25);
    enable = 1'b0; cyc(25);
    enable = 1'b1; cyc(15);
    reset_n = 1'b0; cyc(1);
    chk_reset("mid-run reset state");
    reset_n = 1'b1; cyc(10);
    do_load(255, 1); cyc(600);
    do_load(1, 255); cyc(600);
    for (int k = 0; k < 4000; k++) begin
      r = int'($urandom_range(0, 199));
      if (r < 4) enable = ~enable;
      load     = (r >= 4 && r < 24);
      high_cnt = CNT_W'($urandom_range(0, 6));
      low_cnt  = CNT_W'($urandom_range(0, 6));
      reset_n  = !(r == 199 && ($urandom_range(0, 3) == 0));
      cyc(1);
    end
    load = 1'b0; reset_n = 1'b1; enable = 1'b0;
    cyc(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/duty_clkdiv.md
Name: duty_clkdiv

Overview:
- Synthesizable, programmable duty-cycle clock divider; replaces behavioural clock generation with real RTL.
- Consumes the system clock produced by the clock-generation stage and derives a divided clock with programmable high/low phases, plus edge ticks, for downstream sequential logic.
- Configuration is double-buffered and applied only on period boundaries, so the output never produces runt pulses.

Parameters:
- CNT_W, 8, width of the high/low phase counts; maximum phase length 2^CNT_W-1 cycles.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  run request; sampled every cycle.
- load  in  1  single-cycle pulse; captures high_cnt/low_cnt into the pending registers.
- high_cnt  in  CNT_W  number of cycles clk_out is high per period.
- low_cnt  in  CNT_W  number of cycles clk_out is low per period.
- clk_out  out  1  registered divided clock.
- rise_tick  out  1  high in the first cycle of each high phase.
- fall_tick  out  1  high in the first cycle of each low phase.
- busy  out  1  high whenever state != IDLE.
- cfg_err  out  1  one-cycle pulse when a rejected load occurs.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; clk_out, rise_tick, fall_tick, busy and cfg_err all 0.
  - Active config act_high=1, act_low=1 (divide-by-2).
  - pend_valid=0. Reset overrides everything, including mid-period operation.
- Load handling:
  - load with high_cnt!=0 and low_cnt!=0: pend_high/pend_low are captured and pend_valid is set.
  - load with either count equal to 0: nothing is captured; cfg_err=1 in the next cycle only.
  - Repeated loads before a boundary: the last accepted load wins.
- States: IDLE, HIGH, LOW. Phase counter cnt is CNT_W bits and counts from 1 upward.
- IDLE:
  - clk_out=0.
  - When enable=1 is sampled: apply pending config if pend_valid (act<=pend, pend_valid<=0), go to HIGH, cnt<=1.
  - clk_out=1 and rise_tick=1 from the next cycle (1-cycle start latency).
- HIGH:
  - When cnt==act_high: go to LOW, cnt<=1; clk_out=0 and fall_tick=1 in the next cycle.
  - Otherwise cnt increments.
- LOW:
  - When cnt==act_low, this is the period boundary:
    - enable=1: apply pend if pend_valid, go to HIGH, rise_tick=1.
    - enable=0: go to IDLE.
  - Otherwise cnt increments.
- Period is exactly act_high+act_low cycles. Config changes never take effect mid-period.
- Dropping enable mid-period: the current period completes in full, then the block goes to IDLE; busy falls in the cycle clk_out would have risen.
- Load in the same cycle as a boundary: the previously pending values are applied; the new values become pending with pend_valid=1.
- Enable reasserted in the same cycle IDLE is entered: no restart until IDLE samples enable (one idle cycle minimum).
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DUTY_CLKDIV_PERIOD_COUNT_EN.
- Defined:
  - Adds output period_count (16 bits), which increments on every rise_tick and wraps 0xFFFF->0x0000.
  - Reset value 0; not cleared by IDLE.
- Undefined:
  - The port and its logic are absent; all other behaviour is identical.

Test Plan:
- Release reset, enable=1, no load -> clk_out 1,0,1,0 with period 2; rise_tick every 2 cycles; busy=1.
- In IDLE, load high=3 low=7, then enable=1 -> 1 cycle after enable clk_out is high for 3 cycles, then low for 7; rise_tick every 10 cycles; fall_tick 3 cycles after each rise_tick.
- Running 3/7, load high=2 low=2 during the 2nd high cycle -> current period finishes 3/7, next periods are 2/2; load 5/5 exactly on the boundary cycle -> one 2/2 period, then 5/5.
- load high=0 low=4 -> cfg_err=1 for exactly one cycle; waveform unchanged; pend_valid unchanged.
- Running 3/7, drop enable in the 1st high cycle -> full 10-cycle period completes, then clk_out=0 and busy=0; no further rise_tick.
- Running 3/7, pull reset_n low in a high cycle -> next edge: clk_out=0, busy=0, IDLE; after release with enable=1 the output is 1/1; with DUTY_CLKDIV_PERIOD_COUNT_EN defined, period_count=0 after reset and counts 1,2,3.
